// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states and timing.
// Imported by the multiplier and its shift stage.
package alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } mul_state_t;

    // accept edge plus one accumulate edge per operand bit
    localparam int MUL_LATENCY = 33;

endpackage

// File: rtl/shift_left_logical.sv
// Combinational logical left shift: out = in << shamt.
// Shared shift stage feeding the multiplier accumulate path.
module shift_left_logical
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]         in,
    input  logic [$clog2(N)-1:0] shamt,
    output logic [N-1:0]         out
);

    // zero-filling shift
    always_comb begin
        out = in << shamt;
    end

endmodule

// File: rtl/multiplier_shift_add.sv
// Multi-cycle shift-and-add multiplier, low N bits of a*b (RISC-V MUL).
// One bit of b per cycle, fixed 32-cycle data-independent latency.
module multiplier_shift_add
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] product
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mul_state_t    state;
    mul_state_t    state_next;
    logic [CW-1:0] count;
    logic [N-1:0]  acc;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  shifted;
    logic          accept;

    shift_left_logical #(.N(N)) u_shift (
        .in    (a_reg),
        .shamt (count),
        .out   (shifted)
    );

    assign accept  = i_valid && o_ready;
    assign product = acc;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state and handshake outputs; ready is held low during reset
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        unique case (state)
            S_IDLE: begin
                o_ready = rst_n;
                if (accept) begin
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (count == LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // operand capture and per-bit accumulation; count wraps after the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            acc   <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                S_BUSY: begin
                    if (b_reg[count]) begin
                        acc <= acc + shifted;
                    end
                    count <= count + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_shift_add.sv
// Directed and random checks of the shift-and-add multiplier.
// Expected products are hand-computed or taken from the * operator.
module tb_multiplier_shift_add;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] product;

    int n_cmp;
    int n_bad;

    multiplier_shift_add #(.N(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .a       (a_in),
        .b       (b_in),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts at posedge+1 with the block idle. Returns once o_valid is seen.
    // lat counts edges with the accept edge as 1.
    task automatic run_mul(input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] prod, output int lat);
        a_in = x;
        b_in = y;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        lat = 1;
        while (o_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        prod = product;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready got %b want 0", o_ready);
        end
        n_cmp++;
        if (o_valid !== 1'b0 || product !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_out got v=%b p=%h want v=0 p=0",
                     o_valid, product);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL release_ready got %b want 1", o_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [31:0] p;
        int lat;
        i_ready = 1'b1;
        run_mul(32'd3, 32'd5, p, lat);
        n_cmp++;
        if (lat !== 33) begin
            n_bad++;
            $display("FAIL basic_latency got %0d want 33", lat);
        end
        n_cmp++;
        if (p !== 32'd15) begin
            n_bad++;
            $display("FAIL basic_product got %h want %h", p, 32'd15);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_idle got v=%b r=%b want v=0 r=1",
                     o_valid, o_ready);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] ve [6];
        logic [31:0] p;
        int lat;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; ve[0] = 32'h0000_0001;
        va[1] = 32'h8000_0000; vb[1] = 32'h0000_0002; ve[1] = 32'h0000_0000;
        va[2] = 32'h0000_0000; vb[2] = 32'h1234_5678; ve[2] = 32'h0000_0000;
        va[3] = 32'hDEAD_BEEF; vb[3] = 32'h0000_0001; ve[3] = 32'hDEAD_BEEF;
        va[4] = 32'h0000_0001; vb[4] = 32'h8000_0000; ve[4] = 32'h8000_0000;
        va[5] = 32'h0001_0003; vb[5] = 32'h0001_0005; ve[5] = 32'h0008_000F;
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_mul(va[i], vb[i], p, lat);
            n_cmp++;
            if (p !== ve[i] || lat !== 33) begin
                n_bad++;
                $display("FAIL vector%0d got p=%h lat=%0d want p=%h lat=33",
                         i, p, lat, ve[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int lat;
        i_ready = 1'b0;
        a_in = 32'd3;
        b_in = 32'd9;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 1;
        repeat (4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        a_in = 32'd7;
        b_in = 32'd7;
        i_valid = 1'b1;
        #1;
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ready got %b want 0", o_ready);
        end
        while (o_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 20) i_valid = 1'b0;
        end
        n_cmp++;
        if (o_valid !== 1'b1 || product !== 32'd27 || o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_result got v=%b p=%h r=%b want v=1 p=%h r=0",
                     o_valid, product, o_ready, 32'd27);
        end
        held = product;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (o_valid !== 1'b1 || product !== held) begin
                n_bad++;
                $display("FAIL bp_hold%0d got v=%b p=%h want v=1 p=%h",
                         k, o_valid, product, held);
            end
        end
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release got v=%b r=%b want v=0 r=1",
                     o_valid, o_ready);
        end
    endtask

    task automatic test_abort();
        logic [31:0] p;
        int lat;
        int seen;
        i_ready = 1'b1;
        a_in = 32'd5;
        b_in = 32'd3;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (16) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0 || product !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_reset got v=%b r=%b p=%h want v=0 r=0 p=0",
                     o_valid, o_ready, product);
        end
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_ready got %b want 1", o_ready);
        end
        @(posedge clk);
        #1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (o_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL abort_novalid got %0d valid cycles want 0", seen);
        end
        run_mul(32'd6, 32'd7, p, lat);
        n_cmp++;
        if (p !== 32'd42 || lat !== 33) begin
            n_bad++;
            $display("FAIL abort_fresh got p=%h lat=%0d want p=%h lat=33",
                     p, lat, 32'd42);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] want;
        logic [31:0] p;
        int lat;
        i_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            want = x * y;
            run_mul(x, y, p, lat);
            n_cmp++;
            if (p !== want || lat !== 33) begin
                n_bad++;
                $display("FAIL random%0d a=%h b=%h got p=%h lat=%0d want p=%h",
                         i, x, y, p, lat, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        a_in = '0;
        b_in = '0;
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
